bus_mem_responder: RTL and testbench

//  Slave/responder end of the CPU bus read/write channels. Serves one transaction at a time

---
 rtl/bus_mem_responder.sv | 141 ++++++++++++++
 tb/tb_bus_mem_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// Single-outstanding bus responder backed by a byte-addressed memory.
// Reads and writes share one FSM; a read wins when both request in IDLE.
module bus_mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              readAddr_valid,
  output logic              readAddr_ready,
  input  logic [ADDR_W-1:0] readAddr_addr,
  output logic              readData_valid,
  input  logic              readData_ready,
  output logic [31:0]       readData_data,
  input  logic              writeAddr_valid,
  output logic              writeAddr_ready,
  input  logic [ADDR_W-1:0] writeAddr_addr,
  input  logic              writeData_valid,
  output logic              writeData_ready,
  input  logic [31:0]       writeData_data,
  input  logic [3:0]        writeData_strb,
  output logic              writeResp_valid,
  input  logic              writeResp_ready
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_RESP
  } state_t;

  state_t            state, stateNext;
  logic [3:0]        counter, counterNext;
  logic [ADDR_W-1:0] addrReg;
  logic [ADDR_W-1:0] rdAddr;
  logic [ADDR_W-1:0] wrAddr;
  logic [31:0]       rdWord;
  logic              readAccept;
  logic              writeAccept;
  logic              enterRdResp;
  logic              enterWrResp;
  logic              rdDone;
  logic              wrDone;

  logic [7:0] mem [0:(2**ADDR_W)-1];

  // Ready is masked during reset so no handshake can be seen while reset wins.
  assign readAddr_ready  = (state == IDLE) && !rst;
  assign writeAddr_ready = (state == IDLE) && !rst && writeAddr_valid
                           && writeData_valid && !readAddr_valid;
  assign writeData_ready = writeAddr_ready;

  assign readAccept  = readAddr_valid && readAddr_ready;
  assign writeAccept = writeAddr_ready;
  assign rdDone      = (state == RD_RESP) && readData_ready;
  assign wrDone      = (state == WR_RESP) && writeResp_ready;

  // With zero latency the word is sampled straight from the incoming address.
  assign rdAddr = (state == IDLE) ? (readAddr_addr & ~ADDR_W'(3)) : addrReg;
  assign wrAddr = writeAddr_addr & ~ADDR_W'(3);
  assign rdWord = {mem[rdAddr + ADDR_W'(3)], mem[rdAddr + ADDR_W'(2)],
                   mem[rdAddr + ADDR_W'(1)], mem[rdAddr]};

  assign enterRdResp = (readAccept && (LAT == 4'd0)) ||
                       ((state == RD_WAIT) && (counter == 4'd0));
  assign enterWrResp = (writeAccept && (LAT == 4'd0)) ||
                       ((state == WR_WAIT) && (counter == 4'd0));

  always_comb begin
    stateNext   = state;
    counterNext = counter;
    case (state)
      IDLE: begin
        if (readAccept) begin
          if (LAT == 4'd0) begin
            stateNext = RD_RESP;
          end else begin
            stateNext   = RD_WAIT;
            counterNext = LAT - 4'd1;
          end
        end else if (writeAccept) begin
          if (LAT == 4'd0) begin
            stateNext = WR_RESP;
          end else begin
            stateNext   = WR_WAIT;
            counterNext = LAT - 4'd1;
          end
        end
      end
      RD_WAIT: begin
        if (counter == 4'd0) stateNext = RD_RESP;
        else                 counterNext = counter - 4'd1;
      end
      RD_RESP: if (readData_ready) stateNext = IDLE;
      WR_WAIT: begin
        if (counter == 4'd0) stateNext = WR_RESP;
        else                 counterNext = counter - 4'd1;
      end
      WR_RESP: if (writeResp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      counter         <= 4'd0;
      addrReg         <= '0;
      readData_valid  <= 1'b0;
      readData_data   <= 32'd0;
      writeResp_valid <= 1'b0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
      if (readAccept) addrReg <= readAddr_addr & ~ADDR_W'(3);
      if (enterRdResp) begin
        readData_valid <= 1'b1;
        readData_data  <= rdWord;
      end else if (rdDone) begin
        readData_valid <= 1'b0;
        readData_data  <= 32'd0;
      end
      if (enterWrResp)  writeResp_valid <= 1'b1;
      else if (wrDone)  writeResp_valid <= 1'b0;
    end
  end

  // Memory contents survive reset; only enabled lanes are written.
  always_ff @(posedge clk) begin
    if (writeAccept) begin
      for (int i = 0; i < 4; i++) begin
        if (writeData_strb[i]) mem[wrAddr + ADDR_W'(i)] <= writeData_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a byte-array memory model and the fixed response latency.
module tb_bus_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        readAddr_valid, readAddr_ready;
  logic [15:0] readAddr_addr;
  logic        readData_valid, readData_ready;
  logic [31:0] readData_data;
  logic        writeAddr_valid, writeAddr_ready;
  logic [15:0] writeAddr_addr;
  logic        writeData_valid, writeData_ready;
  logic [31:0] writeData_data;
  logic [3:0]  writeData_strb;
  logic        writeResp_valid, writeResp_ready;

  logic        rstZ;
  logic        raValidZ, raReadyZ;
  logic [15:0] raAddrZ;
  logic        rdValidZ, rdReadyZ;
  logic [31:0] rdDataZ;
  logic        waValidZ, waReadyZ;
  logic [15:0] waAddrZ;
  logic        wdValidZ, wdReadyZ;
  logic [31:0] wdDataZ;
  logic [3:0]  wdStrbZ;
  logic        wrValidZ, wrReadyZ;

  int checks = 0;
  int errors = 0;
  logic [7:0] refMem [0:65535];

  always #5 clk = ~clk;

  bus_mem_responder #(.ADDR_W(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .readAddr_valid(readAddr_valid), .readAddr_ready(readAddr_ready),
    .readAddr_addr(readAddr_addr),
    .readData_valid(readData_valid), .readData_ready(readData_ready),
    .readData_data(readData_data),
    .writeAddr_valid(writeAddr_valid), .writeAddr_ready(writeAddr_ready),
    .writeAddr_addr(writeAddr_addr),
    .writeData_valid(writeData_valid), .writeData_ready(writeData_ready),
    .writeData_data(writeData_data), .writeData_strb(writeData_strb),
    .writeResp_valid(writeResp_valid), .writeResp_ready(writeResp_ready)
  );

  bus_mem_responder #(.ADDR_W(16), .LATENCY(0)) dutZ (
    .clk(clk), .rst(rstZ),
    .readAddr_valid(raValidZ), .readAddr_ready(raReadyZ),
    .readAddr_addr(raAddrZ),
    .readData_valid(rdValidZ), .readData_ready(rdReadyZ),
    .readData_data(rdDataZ),
    .writeAddr_valid(waValidZ), .writeAddr_ready(waReadyZ),
    .writeAddr_addr(waAddrZ),
    .writeData_valid(wdValidZ), .writeData_ready(wdReadyZ),
    .writeData_data(wdDataZ), .writeData_strb(wdStrbZ),
    .writeResp_valid(wrValidZ), .writeResp_ready(wrReadyZ)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] modelWord(input logic [15:0] addr);
    logic [15:0] a;
    a = addr & 16'hFFFC;
    return {refMem[a + 16'd3], refMem[a + 16'd2], refMem[a + 16'd1], refMem[a]};
  endfunction

  task automatic modelWrite(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [15:0] a;
    a = addr & 16'hFFFC;
    for (int i = 0; i < 4; i++)
      if (strb[i]) refMem[a + 16'(i)] = data[8*i +: 8];
  endtask

  task automatic applyStimulus(input logic isWrite, input logic [15:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    if (isWrite) begin
      writeAddr_valid = 1'b1;
      writeData_valid = 1'b1;
      writeAddr_addr  = addr;
      writeData_data  = data;
      writeData_strb  = strb;
    end else begin
      readAddr_valid = 1'b1;
      readAddr_addr  = addr;
    end
    #1;
  endtask

  task automatic doRead(input logic [15:0] addr, input int hold);
    logic [31:0] exp;
    int n;
    exp = modelWord(addr);
    applyStimulus(1'b0, addr, 32'd0, 4'd0);
    checkOutput("rd_addr_ready", readAddr_ready, 1);
    tick();
    readAddr_valid = 1'b0;
    readAddr_addr  = 16'($urandom);
    n = 1;
    while (!readData_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("rd_latency", n, LAT + 1);
    checkOutput("rd_data", readData_data, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("rd_hold_valid", readData_valid, 1);
      checkOutput("rd_hold_data", readData_data, exp);
    end
    readData_ready = 1'b1;
    tick();
    readData_ready = 1'b0;
    checkOutput("rd_drop_valid", readData_valid, 0);
    checkOutput("rd_drop_data", readData_data, 0);
    checkOutput("rd_idle_ready", readAddr_ready, 1);
  endtask

  task automatic doWrite(input logic [15:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold);
    int n;
    applyStimulus(1'b1, addr, data, strb);
    checkOutput("wr_ready", {writeAddr_ready, writeData_ready}, 2'b11);
    tick();
    writeAddr_valid = 1'b0;
    writeData_valid = 1'b0;
    modelWrite(addr, data, strb);
    n = 1;
    while (!writeResp_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("wr_latency", n, LAT + 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("wr_hold_valid", writeResp_valid, 1);
    end
    writeResp_ready = 1'b1;
    tick();
    writeResp_ready = 1'b0;
    checkOutput("wr_drop_valid", writeResp_valid, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {readAddr_ready, writeAddr_ready, writeData_ready,
                      readData_valid, writeResp_valid}, 0);
    checkOutput({tag, "_data"}, readData_data, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic bad;
    logic [15:0] a;
    rst = 1'b1;  rstZ = 1'b1;
    readAddr_valid = 0; readAddr_addr = 0; readData_ready = 0;
    writeAddr_valid = 0; writeAddr_addr = 0; writeData_valid = 0;
    writeData_data = 0; writeData_strb = 0; writeResp_ready = 0;
    raValidZ = 0; raAddrZ = 0; rdReadyZ = 0; waValidZ = 0; waAddrZ = 0;
    wdValidZ = 0; wdDataZ = 0; wdStrbZ = 0; wrReadyZ = 0;
    for (int i = 0; i < 65536; i++) refMem[i] = 8'h00;

    tick(); tick();
    checkAllZero("reset_outputs");
    rst = 1'b0;  rstZ = 1'b0;
    #1;
    checkOutput("post_reset_ready", readAddr_ready, 1);

    $display("[TB] word read with immediate ready");
    doWrite(16'h8000, 32'h44332211, 4'hF, 0);
    doRead(16'h8000, 0);

    $display("[TB] misaligned read with stalled ready");
    doRead(16'h8002, 5);

    $display("[TB] strobed write and readback");
    doWrite(16'h8004, 32'h0, 4'hF, 0);
    doWrite(16'h8004, 32'hDEADBEEF, 4'b0101, 2);
    checkOutput("strobe_model", modelWord(16'h8004), 32'h00AD00EF);
    doRead(16'h8004, 0);

    $display("[TB] simultaneous read and write");
    doWrite(16'h8008, 32'h01020304, 4'hF, 0);
    readAddr_valid  = 1'b1; readAddr_addr  = 16'h8008;
    writeAddr_valid = 1'b1; writeAddr_addr = 16'h8008;
    writeData_valid = 1'b1; writeData_data = 32'hA5A55A5A; writeData_strb = 4'hF;
    #1;
    checkOutput("arb_read_ready", readAddr_ready, 1);
    checkOutput("arb_write_ready", {writeAddr_ready, writeData_ready}, 0);
    tick();
    readAddr_valid = 1'b0;
    #1;
    bad = 1'b0;
    n = 1;
    while (!readData_valid && n < 40) begin
      if (writeAddr_ready || writeData_ready) bad = 1'b1;
      tick();
      n++;
    end
    if (writeAddr_ready || writeData_ready) bad = 1'b1;
    checkOutput("arb_rd_latency", n, LAT + 1);
    checkOutput("arb_rd_data", readData_data, 32'h01020304);
    checkOutput("arb_write_held", bad, 0);
    readData_ready = 1'b1;
    tick();
    readData_ready = 1'b0;
    #1;
    checkOutput("arb_write_now_ready", {writeAddr_ready, writeData_ready}, 2'b11);
    tick();
    writeAddr_valid = 1'b0;
    writeData_valid = 1'b0;
    modelWrite(16'h8008, 32'hA5A55A5A, 4'hF);
    n = 1;
    while (!writeResp_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("arb_wr_latency", n, LAT + 1);
    writeResp_ready = 1'b1;
    tick();
    writeResp_ready = 1'b0;
    doRead(16'h8008, 1);

    $display("[TB] reset during read wait");
    applyStimulus(1'b0, 16'h8000, 32'd0, 4'd0);
    tick();
    readAddr_valid = 1'b0;
    rst = 1'b1;
    tick();
    checkAllZero("rst_mid_read");
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (readData_valid) bad = 1'b1;
    end
    checkOutput("rst_no_read_valid", bad, 0);
    doRead(16'h8000, 0);

    $display("[TB] reset during write wait");
    applyStimulus(1'b1, 16'h800C, 32'h5566_7788, 4'b1010);
    tick();
    writeAddr_valid = 1'b0;
    writeData_valid = 1'b0;
    modelWrite(16'h800C, 32'h5566_7788, 4'b1010);
    rst = 1'b1;
    tick();
    checkAllZero("rst_mid_write");
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (writeResp_valid) bad = 1'b1;
    end
    checkOutput("rst_no_write_resp", bad, 0);
    doRead(16'h800C, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 64; i++)
      doWrite(16'h8100 + 16'(4 * i), $urandom, 4'hF, 0);
    for (int i = 0; i < 60; i++) begin
      a = 16'h8100 + 16'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1)
        doWrite(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      else
        doRead(a, $urandom_range(0, 3));
    end

    $display("[TB] zero-latency instance at top of memory");
    waValidZ = 1'b1; wdValidZ = 1'b1; waAddrZ = 16'hFFFC;
    wdDataZ = 32'hCAFEF00D; wdStrbZ = 4'hF;
    #1;
    checkOutput("z_wr_ready", {waReadyZ, wdReadyZ}, 2'b11);
    tick();
    waValidZ = 1'b0; wdValidZ = 1'b0;
    checkOutput("z_wr_resp", wrValidZ, 1);
    wrReadyZ = 1'b1;
    tick();
    wrReadyZ = 1'b0;
    checkOutput("z_wr_drop", wrValidZ, 0);
    raValidZ = 1'b1; raAddrZ = 16'hFFFE;
    #1;
    checkOutput("z_rd_ready", raReadyZ, 1);
    tick();
    raValidZ = 1'b0;
    checkOutput("z_rd_valid", rdValidZ, 1);
    checkOutput("z_rd_data", rdDataZ, 32'hCAFEF00D);
    rdReadyZ = 1'b1;
    tick();
    rdReadyZ = 1'b0;
    checkOutput("z_rd_drop", rdValidZ, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
